// File: rtl/segasys1_sndcmd_ctl_if.sv
// Sound-command bus between the main CPU, the command scheduler and the sound CPU.
// The master side drives the CPU strobes and data; the slave side is the scheduler.
interface segasys1_sndcmd_ctl_if #(
    parameter int DEPTH_LOG2 = 2
);
    logic                  MCPU_WR;
    logic [7:0]            MCPU_DO;
    logic                  SCPU_RD;
    logic [7:0]            SCPU_DI;
    logic                  SCPU_NMI;
    logic                  FULL;
    logic                  EMPTY;
    logic [DEPTH_LOG2:0]   COUNT;
    logic [7:0]            DROPCNT;

    modport master (
        output MCPU_WR, MCPU_DO, SCPU_RD,
        input  SCPU_DI, SCPU_NMI, FULL, EMPTY, COUNT, DROPCNT
    );

    modport slave (
        input  MCPU_WR, MCPU_DO, SCPU_RD,
        output SCPU_DI, SCPU_NMI, FULL, EMPTY, COUNT, DROPCNT
    );
endinterface

// File: rtl/segasys1_sndcmd_ctl.sv
// System 1 sound-command scheduler: queues main-CPU SNDRQ writes in a small FIFO,
// presents the head byte to the sound CPU and issues exactly one NMI per command,
// with a guaranteed NMI-low gap between consecutive commands.
module segasys1_sndcmd_ctl #(
    parameter int DEPTH_LOG2 = 2,
    parameter int GAP_CYC    = 96
) (
    input  logic                 CLK48M,
    input  logic                 RESETn,
    segasys1_sndcmd_ctl_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_GAP
    } state_t;

    // Two-stage input sampling plus "seen low since reset" qualifiers
    logic            wr1_reg, wr2_reg, rd1_reg, rd2_reg;
    logic            wr_armed_reg, rd_armed_reg;
    logic [7:0]      do1_reg;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic                  full_reg, empty_reg;
    logic [7:0]            drop_reg;
    logic [7:0]            di_reg;

    state_t                state_reg;
    logic [GAP_W-1:0]      gap_reg;
    logic                  nmi_reg;

    logic                  push, pop, do_push, do_pop, drop;
    logic [CW-1:0]         count_next;
    logic [DEPTH_LOG2-1:0] rd_ptr_next;
    logic [7:0]            head_next;

    // Sample the CPU strobes; a strobe held high across reset must be seen low before it counts
    always_ff @(posedge CLK48M or negedge RESETn) begin
        if (!RESETn) begin
            wr1_reg      <= 1'b0;
            wr2_reg      <= 1'b0;
            rd1_reg      <= 1'b0;
            rd2_reg      <= 1'b0;
            do1_reg      <= 8'h00;
            wr_armed_reg <= 1'b0;
            rd_armed_reg <= 1'b0;
        end else begin
            wr1_reg      <= bus.MCPU_WR;
            wr2_reg      <= wr1_reg;
            rd1_reg      <= bus.SCPU_RD;
            rd2_reg      <= rd1_reg;
            do1_reg      <= bus.MCPU_DO;
            wr_armed_reg <= wr_armed_reg | ~bus.MCPU_WR;
            rd_armed_reg <= rd_armed_reg | ~rd1_reg;
        end
    end

    // Push on write rising edge, pop at end of sound-CPU read; a full FIFO accepts a push only alongside a pop
    always_comb begin
        push        = wr1_reg & ~wr2_reg & wr_armed_reg;
        pop         = ~rd1_reg & rd2_reg & rd_armed_reg;
        do_pop      = pop & ~empty_reg;
        do_push     = push & (~full_reg | pop);
        drop        = push & full_reg & ~pop;
        count_next  = count_reg + CW'(do_push) - CW'(do_pop);
        rd_ptr_next = rd_ptr_reg + DEPTH_LOG2'(do_pop);
        // When the pushed byte lands in an otherwise empty FIFO it is the new head
        head_next   = (count_reg == CW'(do_pop)) ? do1_reg : mem[rd_ptr_next];
    end

    // FIFO storage, no reset: contents are irrelevant while the pointers say empty
    always_ff @(posedge CLK48M) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= do1_reg;
        end
    end

    // FIFO pointers, occupancy flags, drop counter and the presented command byte
    always_ff @(posedge CLK48M or negedge RESETn) begin
        if (!RESETn) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
            drop_reg   <= 8'h00;
            di_reg     <= 8'h00;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
            full_reg  <= (count_next == CW'(DEPTH));
            empty_reg <= (count_next == '0);
            if (drop && drop_reg != 8'hFF) begin
                drop_reg <= drop_reg + 8'h01;
            end
            if (count_next != '0) begin
                di_reg <= head_next;
            end
        end
    end

    // NMI sequencer: raise for a waiting command, drop on the read, then enforce the low gap
    always_ff @(posedge CLK48M or negedge RESETn) begin
        if (!RESETn) begin
            state_reg <= ST_IDLE;
            gap_reg   <= '0;
            nmi_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!empty_reg) begin
                        state_reg <= ST_ASSERT;
                        nmi_reg   <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (pop) begin
                        state_reg <= ST_GAP;
                        gap_reg   <= GAP_LOAD;
                        nmi_reg   <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (gap_reg == '0) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        gap_reg <= gap_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    nmi_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.SCPU_DI  = di_reg;
    assign bus.SCPU_NMI = nmi_reg;
    assign bus.FULL     = full_reg;
    assign bus.EMPTY    = empty_reg;
    assign bus.COUNT    = count_reg;
    assign bus.DROPCNT  = drop_reg;
endmodule

// File: tb/tb_segasys1_sndcmd_ctl.sv
// Bench for the sound-command scheduler: queue-based reference model, randomized bytes.
module tb_segasys1_sndcmd_ctl;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    // Reference model: command queue, drop counter, last byte shown to the sound CPU
    logic [7:0] model_q[$];
    int         model_drop;
    logic [7:0] model_last;

    // NMI low-run lengths recorded at each rising NMI
    int   lows[$];
    int   low_run;
    bit   prev_nmi;

    segasys1_sndcmd_ctl_if #(.DEPTH_LOG2(2)) bus ();

    segasys1_sndcmd_ctl #(.DEPTH_LOG2(2), .GAP_CYC(96)) dut (
        .CLK48M (clk),
        .RESETn (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        low_run  = 0;
        prev_nmi = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.SCPU_NMI === 1'b1 && !prev_nmi) lows.push_back(low_run);
            if (bus.SCPU_NMI === 1'b1) low_run = 0;
            else low_run++;
            prev_nmi = (bus.SCPU_NMI === 1'b1);
        end
    end

    function automatic void model_write(input logic [7:0] d);
        if (model_q.size() < 4) model_q.push_back(d);
        else if (model_drop < 255) model_drop++;
        if (model_q.size() > 0) model_last = model_q[0];
    endfunction

    function automatic void model_read();
        if (model_q.size() > 0) void'(model_q.pop_front());
        if (model_q.size() > 0) model_last = model_q[0];
    endfunction

    function automatic void model_reset();
        model_q.delete();
        model_drop = 0;
        model_last = 8'h00;
    endfunction

    task automatic write_cmd(input logic [7:0] d, input int hi, input int lo);
        @(negedge clk);
        bus.MCPU_DO = d;
        bus.MCPU_WR = 1'b1;
        repeat (hi) @(negedge clk);
        bus.MCPU_WR = 1'b0;
        repeat (lo) @(negedge clk);
        $display("wr  data=%02h", d);
    endtask

    task automatic read_cmd(input int hi, input int lo, output logic [7:0] di);
        @(negedge clk);
        bus.SCPU_RD = 1'b1;
        repeat (hi) @(negedge clk);
        di = bus.SCPU_DI;
        bus.SCPU_RD = 1'b0;
        repeat (lo) @(negedge clk);
        $display("rd  data=%02h", di);
    endtask

    task automatic wait_nmi(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus.SCPU_NMI === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus.MCPU_WR = 1'b0;
        bus.MCPU_DO = 8'h00;
        bus.SCPU_RD = 1'b0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.SCPU_DI !== 8'h00 || bus.SCPU_NMI !== 1'b0 || bus.EMPTY !== 1'b1 ||
            bus.FULL !== 1'b0 || bus.COUNT !== 3'd0 || bus.DROPCNT !== 8'h00) begin
            failures++;
            $display("FAIL reset_state: di=%02h nmi=%b empty=%b full=%b count=%0d drop=%0d want 00/0/1/0/0/0",
                     bus.SCPU_DI, bus.SCPU_NMI, bus.EMPTY, bus.FULL, bus.COUNT, bus.DROPCNT);
        end
    endtask

    task automatic test_single();
        logic [7:0] di;
        @(negedge clk);
        bus.MCPU_DO = 8'hA5;
        bus.MCPU_WR = 1'b1;
        model_write(8'hA5);
        @(posedge clk);   // E0
        @(posedge clk);   // E1: FIFO write
        @(negedge clk);
        checks++;
        if (bus.COUNT !== 3'(model_q.size()) || bus.SCPU_DI !== model_last || bus.EMPTY !== 1'b0) begin
            failures++;
            $display("FAIL single_write: count=%0d di=%02h empty=%b want %0d/%02h/0",
                     bus.COUNT, bus.SCPU_DI, bus.EMPTY, model_q.size(), model_last);
        end
        checks++;
        if (bus.SCPU_NMI !== 1'b0) begin
            failures++;
            $display("FAIL single_nmi_early: nmi=%b want 0", bus.SCPU_NMI);
        end
        @(negedge clk);   // after E2
        checks++;
        if (bus.SCPU_NMI !== 1'b1) begin
            failures++;
            $display("FAIL single_nmi_rise: nmi=%b want 1", bus.SCPU_NMI);
        end
        repeat (13) @(negedge clk);
        bus.MCPU_WR = 1'b0;
        repeat (8) @(negedge clk);
        $display("wr  data=a5");
        bus.SCPU_RD = 1'b1;
        repeat (16) @(negedge clk);
        di = bus.SCPU_DI;
        checks++;
        if (di !== 8'hA5) begin
            failures++;
            $display("FAIL single_read_data: di=%02h want a5", di);
        end
        bus.SCPU_RD = 1'b0;
        model_read();
        @(posedge clk);   // F0
        @(negedge clk);
        checks++;
        if (bus.SCPU_NMI !== 1'b1) begin
            failures++;
            $display("FAIL single_nmi_hold: nmi=%b want 1", bus.SCPU_NMI);
        end
        @(negedge clk);   // after F1
        checks++;
        if (bus.SCPU_NMI !== 1'b0 || bus.COUNT !== 3'd0 || bus.EMPTY !== 1'b1 || bus.SCPU_DI !== model_last) begin
            failures++;
            $display("FAIL single_pop: nmi=%b count=%0d empty=%b di=%02h want 0/0/1/%02h",
                     bus.SCPU_NMI, bus.COUNT, bus.EMPTY, bus.SCPU_DI, model_last);
        end
        $display("rd  data=%02h", di);
        repeat (120) @(negedge clk);
    endtask

    task automatic test_burst();
        int s;
        int min_low;
        bit ok;
        logic [7:0] di;
        s = lows.size();
        for (int i = 1; i <= 4; i++) begin
            write_cmd(8'(i), 4, 4);
            model_write(8'(i));
        end
        checks++;
        if (bus.FULL !== 1'b1 || bus.COUNT !== 3'(model_q.size()) || (lows.size() - s) != 1) begin
            failures++;
            $display("FAIL burst_fill: full=%b count=%0d nmi_pulses=%0d want 1/%0d/1",
                     bus.FULL, bus.COUNT, lows.size() - s, model_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            wait_nmi(ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL burst_nmi_timeout: read %0d got no nmi", i);
            end
            read_cmd(4, 4, di);
            checks++;
            if (di !== model_q[0]) begin
                failures++;
                $display("FAIL burst_read: read %0d di=%02h want %02h", i, di, model_q[0]);
            end
            model_read();
        end
        repeat (4) @(negedge clk);
        min_low = 1000;
        for (int i = s + 1; i < lows.size(); i++) if (lows[i] < min_low) min_low = lows[i];
        checks++;
        if ((lows.size() - s) != 4 || min_low < 97 || bus.EMPTY !== 1'b1) begin
            failures++;
            $display("FAIL burst_nmi: pulses=%0d min_low=%0d empty=%b want 4/>=97/1",
                     lows.size() - s, min_low, bus.EMPTY);
        end
        repeat (120) @(negedge clk);
    endtask

    task automatic test_overflow();
        bit ok;
        logic [7:0] di;
        for (int i = 0; i < 6; i++) begin
            write_cmd(8'h10 + 8'(i), 3, 3);
            model_write(8'h10 + 8'(i));
        end
        checks++;
        if (bus.COUNT !== 3'(model_q.size()) || bus.DROPCNT !== 8'(model_drop)) begin
            failures++;
            $display("FAIL overflow_counts: count=%0d drop=%0d want %0d/%0d",
                     bus.COUNT, bus.DROPCNT, model_q.size(), model_drop);
        end
        for (int i = 0; i < 4; i++) begin
            wait_nmi(ok);
            read_cmd(3, 4, di);
            checks++;
            if (!ok || di !== model_q[0]) begin
                failures++;
                $display("FAIL overflow_read: read %0d di=%02h nmi_seen=%b want %02h/1", i, di, ok, model_q[0]);
            end
            model_read();
        end
        repeat (120) @(negedge clk);
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [7:0] di;
        logic [7:0] want;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                d = 8'($urandom);
                write_cmd(d, $urandom_range(1, 6), $urandom_range(3, 6));
                model_write(d);
            end else begin
                want = (model_q.size() > 0) ? model_q[0] : model_last;
                read_cmd($urandom_range(1, 6), $urandom_range(3, 6), di);
                checks++;
                if (di !== want) begin
                    failures++;
                    $display("FAIL random_read: op %0d di=%02h want %02h", n, di, want);
                end
                model_read();
            end
            checks++;
            if (bus.COUNT !== 3'(model_q.size()) || bus.DROPCNT !== 8'(model_drop) ||
                bus.EMPTY !== (model_q.size() == 0) || bus.FULL !== (model_q.size() == 4)) begin
                failures++;
                $display("FAIL random_state: op %0d count=%0d drop=%0d empty=%b full=%b want %0d/%0d",
                         n, bus.COUNT, bus.DROPCNT, bus.EMPTY, bus.FULL, model_q.size(), model_drop);
            end
        end
    endtask

    task automatic test_simul_full();
        bit ok;
        logic [7:0] d;
        logic [7:0] di;
        logic [7:0] newb;
        int drop_before;
        while (model_q.size() < 4) begin
            d = 8'($urandom);
            write_cmd(d, 2, 3);
            model_write(d);
        end
        drop_before = model_drop;
        wait_nmi(ok);
        newb = 8'($urandom);
        @(negedge clk);
        bus.SCPU_RD = 1'b1;
        repeat (4) @(negedge clk);
        di = bus.SCPU_DI;
        bus.SCPU_RD = 1'b0;
        bus.MCPU_DO = newb;
        bus.MCPU_WR = 1'b1;
        repeat (4) @(negedge clk);
        bus.MCPU_WR = 1'b0;
        repeat (4) @(negedge clk);
        $display("rd+wr read=%02h write=%02h", di, newb);
        checks++;
        if (!ok || di !== model_q[0]) begin
            failures++;
            $display("FAIL simul_full_read: di=%02h nmi_seen=%b want %02h/1", di, ok, model_q[0]);
        end
        model_read();
        model_write(newb);
        checks++;
        if (bus.COUNT !== 3'(model_q.size()) || bus.DROPCNT !== 8'(drop_before)) begin
            failures++;
            $display("FAIL simul_full_counts: count=%0d drop=%0d want %0d/%0d",
                     bus.COUNT, bus.DROPCNT, model_q.size(), drop_before);
        end
        for (int i = 0; i < 4; i++) begin
            wait_nmi(ok);
            read_cmd(3, 4, di);
            checks++;
            if (!ok || di !== model_q[0] || (i == 3 && di !== newb)) begin
                failures++;
                $display("FAIL simul_full_drain: read %0d di=%02h want %02h (new byte %02h last)",
                         i, di, model_q[0], newb);
            end
            model_read();
        end
        repeat (120) @(negedge clk);
    endtask

    task automatic test_simul_empty();
        bit ok;
        logic [7:0] di;
        logic [7:0] newb;
        newb = 8'($urandom);
        @(negedge clk);
        bus.SCPU_RD = 1'b1;
        repeat (4) @(negedge clk);
        bus.SCPU_RD = 1'b0;
        bus.MCPU_DO = newb;
        bus.MCPU_WR = 1'b1;
        repeat (4) @(negedge clk);
        bus.MCPU_WR = 1'b0;
        repeat (4) @(negedge clk);
        $display("rd+wr on empty write=%02h", newb);
        model_read();
        model_write(newb);
        checks++;
        if (bus.COUNT !== 3'(model_q.size()) || bus.SCPU_DI !== model_last) begin
            failures++;
            $display("FAIL simul_empty: count=%0d di=%02h want %0d/%02h",
                     bus.COUNT, bus.SCPU_DI, model_q.size(), model_last);
        end
        wait_nmi(ok);
        read_cmd(3, 4, di);
        checks++;
        if (!ok || di !== newb) begin
            failures++;
            $display("FAIL simul_empty_read: di=%02h nmi_seen=%b want %02h/1", di, ok, newb);
        end
        model_read();
        repeat (120) @(negedge clk);
    endtask

    task automatic test_saturate();
        bit ok;
        logic [7:0] d;
        logic [7:0] di;
        while (model_q.size() < 4) begin
            d = 8'($urandom);
            write_cmd(d, 2, 2);
            model_write(d);
        end
        for (int i = 0; i < 300; i++) begin
            d = 8'($urandom);
            write_cmd(d, 2, 2);
            model_write(d);
        end
        checks++;
        if (bus.DROPCNT !== 8'(model_drop) || bus.COUNT !== 3'(model_q.size())) begin
            failures++;
            $display("FAIL saturate: drop=%0d count=%0d want %0d/%0d",
                     bus.DROPCNT, bus.COUNT, model_drop, model_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            wait_nmi(ok);
            read_cmd(3, 4, di);
            checks++;
            if (!ok || di !== model_q[0]) begin
                failures++;
                $display("FAIL saturate_drain: read %0d di=%02h want %02h", i, di, model_q[0]);
            end
            model_read();
        end
        repeat (120) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        write_cmd(8'h33, 3, 3);
        model_write(8'h33);
        write_cmd(8'h44, 3, 3);
        model_write(8'h44);
        wait_nmi(ok);
        checks++;
        if (!ok || bus.COUNT !== 3'(model_q.size())) begin
            failures++;
            $display("FAIL reset_mid_setup: count=%0d nmi_seen=%b want %0d/1", bus.COUNT, ok, model_q.size());
        end
        @(negedge clk);
        bus.MCPU_DO = 8'h5A;
        bus.MCPU_WR = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.SCPU_DI !== 8'h00 || bus.SCPU_NMI !== 1'b0 || bus.EMPTY !== 1'b1 ||
            bus.FULL !== 1'b0 || bus.COUNT !== 3'd0 || bus.DROPCNT !== 8'h00) begin
            failures++;
            $display("FAIL reset_async: di=%02h nmi=%b empty=%b full=%b count=%0d drop=%0d want 00/0/1/0/0/0",
                     bus.SCPU_DI, bus.SCPU_NMI, bus.EMPTY, bus.FULL, bus.COUNT, bus.DROPCNT);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (bus.COUNT !== 3'd0 || bus.EMPTY !== 1'b1 || bus.SCPU_NMI !== 1'b0) begin
            failures++;
            $display("FAIL reset_held_wr: count=%0d empty=%b nmi=%b want 0/1/0", bus.COUNT, bus.EMPTY, bus.SCPU_NMI);
        end
        bus.MCPU_WR = 1'b0;
        repeat (4) @(negedge clk);
        write_cmd(8'h5A, 4, 4);
        model_write(8'h5A);
        checks++;
        if (bus.COUNT !== 3'(model_q.size()) || bus.SCPU_DI !== model_last) begin
            failures++;
            $display("FAIL reset_rearm: count=%0d di=%02h want %0d/%02h",
                     bus.COUNT, bus.SCPU_DI, model_q.size(), model_last);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.MCPU_WR = 1'b0;
        bus.MCPU_DO = 8'h00;
        bus.SCPU_RD = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_random();
        test_simul_full();
        test_simul_empty();
        test_saturate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
